anomaly_event_logger: RTL

ANOMALY_EVENT_LOGGER -- requirements
Module: anomaly_event_logger

---
 rtl/anomaly_event_logger.sv | 116 +++++++++++
 1 files changed

// File: rtl/anomaly_event_logger.sv
// Anomaly event logger: timestamps rising edges of per-channel outlier flags
// into a first-word-fall-through FIFO with drop accounting and an irq level.
module anomaly_event_logger #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned IRQ_THRESH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [3:0]               outlier_flags,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               drop_count,
  output logic                     overflow,
  output logic                     irq
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [31:0] THRESH32 = 32'(IRQ_THRESH);
  localparam logic [AW:0] THRESH   = THRESH32[AW:0];

  typedef logic [AW:0] ptr_t;

  logic [23:0] ts;
  logic [3:0]  flags_d;
  logic [3:0]  rise;
  logic        evt;
  logic [31:0] entry;
  logic [31:0] mem [DEPTH];

  ptr_t        wr_ptr;
  ptr_t        rd_ptr;
  ptr_t        wr_ptr_next;
  ptr_t        rd_ptr_next;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  logic        drop;
  logic [AW:0] count_next;
  logic [7:0]  drop_next;
  logic        overflow_next;
  logic [31:0] head_next;

  assign rise  = outlier_flags & ~flags_d;
  assign evt   = |rise;
  assign entry = {ts, rise, outlier_flags};

  // Extra wrap bit disambiguates full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop   = !empty && rd_ready && !clear;
  assign push  = evt && !clear && (!full || pop);
  assign drop  = evt && !clear && full && !pop;

  assign count = wr_ptr - rd_ptr;

  always_comb begin
    wr_ptr_next   = wr_ptr;
    rd_ptr_next   = rd_ptr;
    drop_next     = drop_count;
    overflow_next = overflow;
    if (clear) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      drop_next     = '0;
      overflow_next = 1'b0;
    end else begin
      if (push) wr_ptr_next = ptr_t'(wr_ptr + 1'b1);
      if (pop)  rd_ptr_next = ptr_t'(rd_ptr + 1'b1);
      if (drop) begin
        overflow_next = 1'b1;
        if (drop_count != 8'hFF) drop_next = drop_count + 8'd1;
      end
    end
    count_next = wr_ptr_next - rd_ptr_next;
  end

  // Next head bypasses the memory when it is the slot being written this cycle.
  always_comb begin
    head_next = mem[rd_ptr_next[AW-1:0]];
    if (push && (rd_ptr_next[AW-1:0] == wr_ptr[AW-1:0])) head_next = entry;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts         <= '0;
      flags_d    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      irq        <= 1'b0;
    end else begin
      ts         <= ts + 24'd1;
      flags_d    <= outlier_flags;
      wr_ptr     <= wr_ptr_next;
      rd_ptr     <= rd_ptr_next;
      rd_valid   <= (count_next != '0);
      if (count_next != '0) rd_data <= head_next;
      drop_count <= drop_next;
      overflow   <= overflow_next;
      irq        <= (count_next >= THRESH) | overflow_next;
    end
  end

endmodule
